// File: rtl/seg7_pkg.sv
// Shared constants and types for the 7-segment number front-end.
package seg7_pkg;

  // Digit codes understood by the display decoder
  localparam logic [3:0] DIG_MINUS = 4'hF;
  localparam logic [3:0] DIG_BLANK = 4'hA;

  // Largest magnitudes that fit in 8 digits (one digit reserved for the sign)
  localparam logic [31:0] POS_LIMIT = 32'd99_999_999;
  localparam logic [31:0] NEG_LIMIT = 32'd9_999_999;

  // Display geometry
  localparam int AN_NUM     = 8;
  localparam int AN_BIT_LEN = 4;

  typedef enum logic [1:0] {
    IDLE,
    CHECK,
    SHIFT,
    FORMAT
  } seg7_ctrl_state_t;

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: a BCD digit of 5 or more gets 3 added
// so that the following left shift carries correctly into the next digit.
module bcd_add3 (
  input  logic [3:0] digit,
  output logic [3:0] adjusted
);

  assign adjusted = (digit >= 4'd5) ? digit + 4'd3 : digit;

endmodule

// File: rtl/seg7_num_ctrl.sv
// Converts a 32-bit binary value into 8 packed display digits using an
// iterative double-dabble engine, with sign, leading-zero blanking and
// overflow handling. num_o only changes once per finished conversion.
module seg7_num_ctrl
  import seg7_pkg::*;
#(
  parameter bit LZ_BLANK = 1'b1,
  parameter int AN_NUM   = 8
) (
  input  logic        clk_i,
  input  logic        rst,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [31:0] value_i,
  input  logic        signed_i,
  output logic [31:0] num_o,
  output logic        done_o,
  output logic        ovf_o
);

  seg7_ctrl_state_t state;

  logic [31:0] value;
  logic        is_signed;
  logic        neg;
  logic        ovf_hit;
  logic [31:0] bcd;
  logic [31:0] bcd_adj;
  logic [31:0] shreg;
  logic [4:0]  cnt;

  logic        neg_c;
  logic [31:0] mag_c;
  logic        ovf_c;

  // Applies sign placement and leading-zero blanking to a finished BCD word
  function automatic logic [31:0] format_digits(input logic [31:0] digits,
                                                input logic        is_neg,
                                                input logic        is_ovf);
    logic [31:0] res;
    int          msd;
    res = digits;
    msd = 0;
    if (is_ovf) begin
      res = '1;
    end else if (LZ_BLANK) begin
      for (int k = 0; k < AN_NUM; k++) begin
        if (digits[k*AN_BIT_LEN +: AN_BIT_LEN] != 4'd0) msd = k;
      end
      for (int k = 0; k < AN_NUM; k++) begin
        if (k > msd) begin
          res[k*AN_BIT_LEN +: AN_BIT_LEN] = (is_neg && (k == msd + 1)) ? DIG_MINUS : DIG_BLANK;
        end
      end
    end else if (is_neg) begin
      res[31:28] = DIG_MINUS;
    end
    return res;
  endfunction

  assign in_ready_o = (state == IDLE);

  // Sign extraction and range check on the latched request
  assign neg_c = is_signed & value[31];
  assign mag_c = neg_c ? (~value + 32'd1) : value;
  assign ovf_c = neg_c ? (mag_c > NEG_LIMIT) : (mag_c > POS_LIMIT);

  for (genvar k = 0; k < AN_NUM; k++) begin : g_add3
    bcd_add3 u_add3 (
      .digit   (bcd[k*AN_BIT_LEN +: AN_BIT_LEN]),
      .adjusted(bcd_adj[k*AN_BIT_LEN +: AN_BIT_LEN])
    );
  end

  // Conversion sequencer: capture, range check, 32 shift steps, format
  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      value     <= '0;
      is_signed <= 1'b0;
      neg       <= 1'b0;
      ovf_hit   <= 1'b0;
      bcd       <= '0;
      shreg     <= '0;
      cnt       <= '0;
      num_o     <= {AN_NUM{DIG_BLANK}};
      done_o    <= 1'b0;
      ovf_o     <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid_i) begin
            value     <= value_i;
            is_signed <= signed_i;
            state     <= CHECK;
          end
        end
        CHECK: begin
          neg     <= neg_c;
          ovf_hit <= ovf_c;
          if (ovf_c) begin
            state <= FORMAT;
          end else begin
            bcd   <= '0;
            shreg <= mag_c;
            cnt   <= '0;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          bcd   <= {bcd_adj[30:0], shreg[31]};
          shreg <= {shreg[30:0], 1'b0};
          cnt   <= cnt + 5'd1;
          if (cnt == 5'd31) state <= FORMAT;
        end
        FORMAT: begin
          num_o  <= format_digits(bcd, neg, ovf_hit);
          done_o <= 1'b1;
          ovf_o  <= ovf_hit;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seg7_num_ctrl.sv
// Bench for seg7_num_ctrl: two instances (blanking on/off) share stimulus.
module tb_seg7_num_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] value = '0;
  logic        signed_in = 1'b0;
  logic        ready1, done1, ovf1, ready0, done0, ovf0;
  logic [31:0] num1, num0;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  seg7_num_ctrl #(.LZ_BLANK(1'b1), .AN_NUM(8)) dut_lz (
    .clk_i(clk), .rst(rst), .in_valid_i(in_valid), .in_ready_o(ready1),
    .value_i(value), .signed_i(signed_in), .num_o(num1), .done_o(done1), .ovf_o(ovf1)
  );

  seg7_num_ctrl #(.LZ_BLANK(1'b0), .AN_NUM(8)) dut_nz (
    .clk_i(clk), .rst(rst), .in_valid_i(in_valid), .in_ready_o(ready0),
    .value_i(value), .signed_i(signed_in), .num_o(num0), .done_o(done0), .ovf_o(ovf0)
  );

  typedef struct {
    logic [31:0] v;
    logic        s;
    logic [31:0] exp_lz;
    logic [31:0] exp_nz;
    logic        ovf;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, required %h", name, act, exp);
  endtask

  // Reference: decimal digits from division, blanking from the digit count
  function automatic logic [31:0] model(input logic [31:0] v, input logic s,
                                        input logic lz, output logic ovf);
    longint      mag;
    longint      p;
    logic        neg;
    int          nd;
    logic [31:0] r;
    logic [3:0]  d;
    neg = s && v[31];
    mag = neg ? (64'sh1_0000_0000 - longint'(v)) : longint'(v);
    ovf = neg ? (mag > 9_999_999) : (mag > 99_999_999);
    if (ovf) return 32'hFFFF_FFFF;
    nd = 1;
    p  = 10;
    while (p <= mag) begin
      nd++;
      p = p * 10;
    end
    r = '0;
    p = 1;
    for (int k = 0; k < 8; k++) begin
      d = 4'((mag / p) % 10);
      p = p * 10;
      if (lz && k >= nd) d = (neg && k == nd) ? 4'hF : 4'hA;
      r[4*k +: 4] = d;
    end
    if (!lz && neg) r[31:28] = 4'hF;
    return r;
  endfunction

  task automatic wait_done(output int lat);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!done1 && lat < 60);
  endtask

  // One full conversion: handshake, latency, results, done pulse width
  task automatic run(input string name, input logic [31:0] v, input logic s,
                     input logic [31:0] e_lz, input logic [31:0] e_nz, input logic e_ovf);
    int lat;
    @(negedge clk);
    chk({name, " ready"}, 32'(ready1), 32'd1);
    value     = v;
    signed_in = s;
    in_valid  = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    wait_done(lat);
    chk({name, " latency"}, 32'(lat), e_ovf ? 32'd2 : 32'd34);
    chk({name, " num lz"}, num1, e_lz);
    chk({name, " num nz"}, num0, e_nz);
    chk({name, " ovf"}, {30'd0, ovf1, ovf0}, {30'd0, e_ovf, e_ovf});
    @(posedge clk);
    #1;
    chk({name, " done drop"}, {30'd0, done1, done0}, 32'd0);
    chk({name, " hold"}, num1, e_lz);
  endtask

  vec_t vecs[$];

  initial begin
    vec_t   t;
    int     lat;
    int     bad;
    logic   eo;
    logic [31:0] rv;
    logic        rs;
    logic [31:0] e1, e0;

    vecs.push_back('{32'd12345,       1'b1, 32'hAAA1_2345, 32'h0001_2345, 1'b0});
    vecs.push_back('{32'hFFFF_FFD6,   1'b1, 32'hAAAA_AF42, 32'hF000_0042, 1'b0});
    vecs.push_back('{32'd0,           1'b0, 32'hAAAA_AAA0, 32'h0000_0000, 1'b0});
    vecs.push_back('{32'd99_999_999,  1'b0, 32'h9999_9999, 32'h9999_9999, 1'b0});
    vecs.push_back('{32'd100_000_000, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1});
    vecs.push_back('{32'hFF67_6981,   1'b1, 32'hF999_9999, 32'hF999_9999, 1'b0});
    vecs.push_back('{32'hFF67_6980,   1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1});
    vecs.push_back('{32'h8000_0000,   1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1});
    vecs.push_back('{32'hFFFF_FFFF,   1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1});
    vecs.push_back('{32'd7,           1'b0, 32'hAAAA_AAA7, 32'h0000_0007, 1'b0});
    vecs.push_back('{32'hFFFF_FFFF,   1'b1, 32'hAAAA_AAF1, 32'hF000_0001, 1'b0});

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset num", num1, 32'hAAAA_AAAA);
    chk("reset ctrl", {28'd0, done1, ovf1, ready1, ready0}, 32'h3);

    // Directed table
    foreach (vecs[i]) begin
      t = vecs[i];
      run($sformatf("vec%0d", i), t.v, t.s, t.exp_lz, t.exp_nz, t.ovf);
    end

    // Requests while busy are ignored; next one accepted right after done
    @(negedge clk);
    value     = 32'd555;
    signed_in = 1'b0;
    in_valid  = 1'b1;
    @(posedge clk);
    #1;
    bad = 0;
    lat = 0;
    do begin
      value = $urandom;
      signed_in = 1'($urandom);
      if (ready1 || ready0) bad++;
      @(posedge clk);
      #1;
      lat++;
    end while (!done1 && lat < 60);
    chk("busy ready low", 32'(bad), 32'd0);
    chk("busy latency", 32'(lat), 32'd34);
    chk("busy result", num1, 32'hAAAA_A555);
    chk("busy ready back", 32'(ready1), 32'd1);
    value     = 32'd31337;
    signed_in = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("back2back accepted", 32'(ready1), 32'd0);
    wait_done(lat);
    chk("back2back latency", 32'(lat), 32'd34);
    chk("back2back lz", num1, 32'hAAA3_1337);
    chk("back2back nz", num0, 32'h0003_1337);

    // Reset in the middle of a conversion
    @(negedge clk);
    value     = 32'd8888;
    signed_in = 1'b0;
    in_valid  = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("midrst num", num1, 32'hAAAA_AAAA);
    chk("midrst num nz", num0, 32'hAAAA_AAAA);
    chk("midrst done", {30'd0, done1, done0}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst ready", {30'd0, ready1, ready0}, 32'd3);
    bad = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done1 || done0 || num1 != 32'hAAAA_AAAA) bad++;
    end
    chk("midrst discarded", 32'(bad), 32'd0);
    run("after rst", 32'd4321, 1'b0, 32'hAAAA_4321, 32'h0000_4321, 1'b0);

    // Randomized conversions against the reference model
    for (int i = 0; i < 40; i++) begin
      case (i % 4)
        0: begin rv = $urandom; rs = 1'($urandom); end
        1: begin rv = $urandom_range(0, 99_999_999); rs = 1'b0; end
        2: begin rv = 32'd0 - 32'($urandom_range(0, 9_999_999)); rs = 1'b1; end
        default: begin rv = $urandom_range(0, 9_999); rs = 1'($urandom); end
      endcase
      e1 = model(rv, rs, 1'b1, eo);
      e0 = model(rv, rs, 1'b0, eo);
      run($sformatf("rand%0d v=%h s=%0d", i, rv, rs), rv, rs, e1, e0, eo);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/seg7_num_ctrl.md
Name: seg7_num_ctrl

Overview:
Sequencing front-end for the 8-digit 7-segment display multiplexer. Accepts a 32-bit binary value over a valid/ready handshake and converts it to the 8-nibble packed digit bus with an iterative double-dabble (shift/add-3) engine. Handles the sign, leading-zero blanking and overflow. The display bus updates atomically, once per completed conversion, so the display never shows a half-converted value.

Parameters:
LZ_BLANK, 1, 1 = leading zeros replaced by blank code; 0 = zeros shown and the minus sign sits in digit 7
AN_NUM, 8, number of display digits (fixed at 8; other values unsupported)

Ports:
clk_i  in  1  clock
rst  in  1  reset, asynchronous, active-high
in_valid_i  in  1  request to convert value_i
in_ready_o  out  1  high only when the FSM is in IDLE
value_i  in  32  binary value, captured on handshake
signed_i  in  1  1 = value_i is two's complement; captured on handshake
num_o  out  32  packed digits to the display; nibble k drives digit k (digit 0 rightmost)
done_o  out  1  one-cycle pulse on the cycle num_o takes a new value
ovf_o  out  1  sticky flag; set if the last conversion overflowed, cleared by the next non-overflow conversion

Behaviour:
- Digit codes: 0-9 are BCD, 4'hF is minus/dash, 4'hA is blank (the display decodes A as all segments off).
- Reset values:
  - num_o = 32'hAAAA_AAAA
  - done_o = 0, ovf_o = 0
  - in_ready_o = 1
  - FSM = IDLE, internal registers 0
- Reset mid-conversion aborts the conversion and discards it. num_o returns to all blank.
- Handshake: a transfer occurs at the edge where in_valid_i && in_ready_o. in_valid_i while busy is ignored (not queued).
- FSM states: IDLE, CHECK, SHIFT, FORMAT.
  - IDLE: on handshake, latch value_i and signed_i -> CHECK.
  - CHECK (1 cycle):
    - neg = signed_i & value[31]
    - mag = neg ? two's-complement negation of value : value (32-bit unsigned; 0x8000_0000 negates to 2^31)
    - ovf = mag > 99_999_999 when !neg, or mag > 9_999_999 when neg
    - ovf -> FORMAT; else clear the 32-bit BCD register, load the shift register with mag, cnt = 0 -> SHIFT.
  - SHIFT (exactly 32 cycles):
    - each cycle, add 3 to every BCD digit >= 5, then shift {bcd, mag} left by 1 and increment cnt.
    - cnt == 31 -> FORMAT.
    - 8 digits suffice because mag < 10^8 after CHECK.
  - FORMAT (1 cycle):
    - ovf: num_o = 32'hFFFF_FFFF.
    - else, LZ_BLANK = 1:
      - every digit above the most significant nonzero digit becomes A.
      - digit 0 always shows, so zero displays as "0".
      - if neg, the F goes in the first digit left of the most significant nonzero digit.
    - else, LZ_BLANK = 0: digits shown verbatim; if neg, digit 7 = F (guaranteed 0 by the overflow limit).
    - Same edge: done_o = 1, ovf_o = ovf -> IDLE.
- Latency, counted from the handshake edge E0:
  - normal: num_o and done_o update at E34
  - overflow: update at E2
  - next handshake possible at the edge after the update
- done_o is high only during the cycle following the update edge.
- num_o holds between updates.

Decomposition:
- seg7_pkg holds:
  - DIG_MINUS = 4'hF, DIG_BLANK = 4'hA
  - POS_LIMIT = 99_999_999, NEG_LIMIT = 9_999_999
  - AN_NUM = 8, AN_BIT_LEN = 4
  - state enum typedef seg7_ctrl_state_t
- One combinational sub-module, bcd_add3 (4-bit in/out: add 3 if >= 5), instantiated 8 times in the SHIFT datapath.
- Sign and blanking logic stays in seg7_num_ctrl.

Test Plan:
- Reset, then value 12345, signed_i = 1 -> num_o = 32'hAAA1_2345 exactly 34 cycles after the handshake, done_o pulse, ovf_o = 0.
- Values -42 (32'hFFFF_FFD6, signed) and 0 -> 32'hAAAA_AF42, then 32'hAAAA_AAA0; rerun with LZ_BLANK = 0 -> 32'hF000_0042 and 32'h0000_0000.
- Boundaries:
  - 99_999_999 -> 32'h9999_9999
  - 100_000_000 -> 32'hFFFF_FFFF at 2-cycle latency, ovf_o = 1
  - -9_999_999 -> 32'hF999_9999
  - -10_000_000 -> overflow
  - 32'h8000_0000 signed -> overflow
  - 32'hFFFF_FFFF unsigned -> overflow
  - a following 7 -> 32'hAAAA_AAA7, ovf_o = 0
- in_valid_i held high with a changing value_i during SHIFT -> in_ready_o = 0, the value is ignored, the first result is unaffected, and the next request is accepted one edge after done_o.
- rst asserted at cycle 10 of a conversion -> num_o = 32'hAAAA_AAAA immediately, no done_o, in_ready_o = 1 after release, and a new conversion completes normally.
